uart_rx_buffer: RTL and testbench
=================================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..256.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rstN  input  1  reset, asynchronous assert, active-low.
REQ-004 rxDone  input  1  receiver done level, not synchronous to clk; held high at least 2 baud periods per frame.
REQ-005 rxErr  input  1  receiver framing error; valid while rxDone high.
REQ-006 rxByte  input  8  received byte; stable while rxDone high.
REQ-007 popReady  input  1  consumer accepts head byte this cycle.
REQ-008 clrFlags  input  1  synchronous clear of overrun and errCount.
REQ-009 popValid  output  1  FIFO non-empty; head byte on popData.
REQ-010 popData  output  8  head byte; first-word-fall-through.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 overrun  output  1  sticky: a good byte was dropped because the FIFO was full.
REQ-013 errCount  output  8  saturating count of frames discarded for rxErr.

Function
REQ-014 rxDone and rxErr each SHALL pass a 2-flop synchronizer; a third flop on rxDone provides rising-edge detect.
REQ-015 A capture event SHALL fire for exactly one clk cycle, 3 clk cycles after the first sampled high of rxDone; a held-high rxDone SHALL NOT produce further events.
REQ-016 On capture, rxByte SHALL be sampled directly (stable by REQ-006), with no synchronizer.
REQ-017 Capture with synchronized rxErr high: byte discarded; errCount += 1, saturating at 255; FIFO unchanged.
REQ-018 Capture with rxErr low and count < DEPTH: byte written at wrPtr; wrPtr += 1 mod DEPTH; count += 1.
REQ-019 Capture with rxErr low and count == DEPTH with no pop that cycle: byte discarded; overrun set to 1; FIFO unchanged.
REQ-020 Pop occurs when popValid && popReady: rdPtr += 1 mod DEPTH; count -= 1.
REQ-021 Simultaneous write and pop: both SHALL take effect; count unchanged; this applies when full, so overrun SHALL NOT be set.
REQ-022 Pop with popValid low SHALL be ignored; a write into an empty FIFO SHALL NOT be poppable in the same cycle.
REQ-023 popValid SHALL be high the cycle after a write into an empty FIFO; popData = mem[rdPtr], registered storage, combinational read.
REQ-024 Pointers SHALL be log2(DEPTH) bits and wrap naturally; full/empty SHALL be derived from count only.
REQ-025 clrFlags SHALL clear overrun and errCount next cycle; a set or increment in the same cycle SHALL take priority over the clear.
REQ-026 The block SHALL be a datapath with no FSM beyond the edge detector; the capture path SHALL have no combinational path from rxDone to any output.

Reset
REQ-027 rstN low SHALL immediately clear synchronizer flops, pointers, count, overrun and errCount, and force popValid low.
REQ-028 popData SHALL be don't-care during and after reset until the first write; memory SHALL NOT be reset.
REQ-029 Reset during a held-high rxDone: after release, the edge detector SHALL start at 0; the held level SHALL produce one capture 3 cycles after release; the byte is taken from the same frame.
REQ-030 Reset release SHALL be synchronized externally; the block SHALL NOT add a reset synchronizer.

Structure
REQ-031 A shared package uart_pkg SHALL hold UART_DATA_WIDTH = 8 and the errCount width; the module SHALL use these constants, not literals.
REQ-032 The 2-flop synchronizer SHALL be one sub-module, uart_sync2, instantiated twice (rxDone, rxErr).
REQ-033 Expected implementation: 150-250 lines including storage and counters.

Verification
REQ-034 Byte 8'b01111010 with rxDone pulse (rxErr=0) and popReady=0 -> popValid rises 4 clk after the rxDone rise; popData=8'b01111010; count=1.
REQ-035 Bytes 8'b01111010 then 8'b10110001 written, then popReady=1 -> popData sequence 8'b01111010, 8'b10110001; popValid low after 2 pops; count=0.
REQ-036 DEPTH=8: 9 good frames, no pops -> count=8, overrun=1, first 8 bytes intact; clrFlags -> overrun=0.
REQ-037 FIFO full, 9th frame capture coincides with a pop -> overrun stays 0, count stays 8, 9th byte read last.
REQ-038 Frame with rxErr=1, then a good frame -> errCount=1, count=1; 300 error frames -> errCount=255.
REQ-039 rstN pulsed low mid-frame with rxDone held high -> outputs cleared at once; exactly one capture after release; no second capture until rxDone toggles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and types.
//   UART_DATA_WIDTH : width of one received character
//   ERR_CNT_WIDTH   : width of the saturating framing-error counter
package uart_pkg;
  localparam int UART_DATA_WIDTH = 8;
  localparam int ERR_CNT_WIDTH   = 8;

  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;
  typedef logic [ERR_CNT_WIDTH-1:0]   err_cnt_t;

  localparam err_cnt_t ERR_CNT_MAX = '1;
endpackage

// File: rtl/uart_rx_buffer_if.sv
// Pop-side handshake of the receive FIFO.
//   popValid : FIFO non-empty, popData holds the head byte
//   popReady : consumer takes the head byte this cycle
//   popData  : head byte (first-word-fall-through)
// master = the buffer, slave = the consumer.
interface uart_rx_buffer_if;
  logic                popValid;
  logic                popReady;
  uart_pkg::uart_byte_t popData;

  modport master (output popValid, output popData, input popReady);
  modport slave  (input popValid, input popData, output popReady);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk  : destination clock
//   rstN : async active-low reset, clears both flops
//   d    : asynchronous input
//   q    : synchronized output (2 clk latency)
module uart_sync2 (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer behind a UART receiver: synchronizes the receiver's done /
// error levels, captures one byte per frame into a FWFT FIFO, and keeps a
// sticky overrun flag and a saturating framing-error count.
//   clk, rstN : clock, async active-low reset
//   rxDone    : async frame-done level from the receiver
//   rxErr     : async framing-error level, valid while rxDone is high
//   rxByte    : received byte, stable while rxDone is high
//   clrFlags  : synchronous clear of overrun and errCount
//   pop       : pop handshake (popValid / popReady / popData)
//   count     : FIFO occupancy
//   overrun   : sticky, a good byte was dropped on a full FIFO
//   errCount  : saturating count of frames discarded for rxErr
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  uart_byte_t             rxByte,
  input  logic                   clrFlags,
  uart_rx_buffer_if.master       pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  output err_cnt_t               errCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------------------------------------------------------- capture
  logic done_s, err_s, done_d, cap;

  uart_sync2 u_done_sync (.clk, .rstN, .d(rxDone), .q(done_s));
  uart_sync2 u_err_sync  (.clk, .rstN, .d(rxErr),  .q(err_s));

  // done_d is the edge-detect flop. The rising edge is registered into cap
  // so the capture strobe comes straight off a flop; rxByte has been stable
  // for several cycles by the time cap is seen, so it is sampled raw.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      done_d <= 1'b0;
      cap    <= 1'b0;
    end else begin
      done_d <= done_s;
      cap    <= done_s & ~done_d;
    end
  end

  // ------------------------------------------------------------------- FIFO
  logic [AW-1:0] wr_ptr, rd_ptr;
  uart_byte_t    mem [DEPTH];
  logic          empty, full, pop_fire, good, wr_en, drop, err_evt;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_fire = pop.popReady & ~empty;
  assign good     = cap & ~err_s;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en    = good & (~full | pop_fire);
  assign drop     = good & full & ~pop_fire;
  assign err_evt  = cap & err_s;

  assign pop.popValid = ~empty;
  assign pop.popData  = mem[rd_ptr];

  // Storage is intentionally not reset; popData is only meaningful while
  // popValid is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rxByte;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ flags
  // A set/increment in the same cycle wins over clrFlags; an error frame at
  // saturation still counts as an increment and so also blocks the clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overrun  <= 1'b0;
      errCount <= '0;
    end else begin
      if (drop)          overrun <= 1'b1;
      else if (clrFlags) overrun <= 1'b0;

      if (err_evt) begin
        if (errCount != ERR_CNT_MAX) errCount <= errCount + ERR_CNT_WIDTH'(1);
      end else if (clrFlags) begin
        errCount <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus randomized
// frames, all compared each cycle against a queue-based reference model.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0, rstN = 1'b1, rxDone = 1'b0, rxErr = 1'b0, clrFlags = 1'b0;
  uart_byte_t rxByte = '0;
  logic [$clog2(DEPTH):0] count;
  logic overrun;
  err_cnt_t errCount;

  uart_rx_buffer_if bus();

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .clrFlags(clrFlags), .pop(bus), .count(count), .overrun(overrun),
    .errCount(errCount)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  // A frame is captured on the 4th rising clk edge after rxDone is seen to
  // rise; the byte joins a queue unless it is an error frame or the queue is
  // full after any pop taken on that same edge.
  typedef struct {
    int         t;
    logic [7:0] b;
    logic       er;
  } ev_t;

  ev_t        sch[$];
  logic [7:0] m_q[$];
  bit         m_ovr  = 1'b0;
  int         m_ecnt = 0;
  bit         m_prev = 1'b0;
  int         e_idx  = 0;
  int         pop_pct = 0, clr_pct = 0;

  task automatic model_edge(input logic done, er, input logic [7:0] b,
                            input logic pr, clr, rst);
    bit  p, evt, set_ovr, err_evt;
    ev_t ev;
    set_ovr = 1'b0;
    err_evt = 1'b0;
    if (!rst) begin
      m_q.delete(); sch.delete();
      m_ovr = 1'b0; m_ecnt = 0; m_prev = 1'b0;
      e_idx++;
      return;
    end
    if (done && !m_prev) sch.push_back('{e_idx + 3, b, er});
    m_prev = done;
    p   = (m_q.size() != 0) && pr;
    evt = (sch.size() != 0) && (sch[0].t == e_idx);
    if (p) void'(m_q.pop_front());
    if (evt) begin
      ev = sch.pop_front();
      if (ev.er) begin
        err_evt = 1'b1;
        if (m_ecnt < 255) m_ecnt++;
      end else if (m_q.size() < DEPTH) begin
        m_q.push_back(ev.b);
      end else begin
        set_ovr = 1'b1;
      end
    end
    if (set_ovr)  m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (!err_evt && clr) m_ecnt = 0;
    e_idx++;
  endtask

  task automatic cmp_all();
    chk("popValid", bus.popValid, m_q.size() != 0);
    if (m_q.size() != 0) chk("popData", bus.popData, m_q[0]);
    chk("count", count, m_q.size());
    chk("overrun", overrun, m_ovr);
    chk("errCount", errCount, m_ecnt);
  endtask

  // One clock: compare at the falling edge, then drive inputs for the next
  // rising edge and advance the model across it.
  task automatic cyc(input logic done, er, input logic [7:0] b,
                     input logic pr, clr, rst);
    @(negedge clk);
    cmp_all();
    rxDone = done; rxErr = er; rxByte = b;
    bus.popReady = pr; clrFlags = clr; rstN = rst;
    model_edge(done, er, b, pr, clr, rst);
  endtask

  function automatic logic rnd(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // hold >= 4 keeps rxDone/rxByte stable through the capture edge; with
  // pop_cap the consumer pops exactly on that capture edge.
  task automatic frame(input logic [7:0] b, input logic er, input int hold,
                       input int gap, input bit pop_cap);
    for (int i = 0; i < hold; i++)
      cyc(1'b1, er, b, pop_cap ? (i == 3) : rnd(pop_pct), rnd(clr_pct), 1'b1);
    for (int i = 0; i < gap; i++)
      cyc(1'b0, er, b, rnd(pop_pct), rnd(clr_pct), 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 1'b0, rxByte, 1'b1, 1'b0, 1'b1);
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    logic [7:0] bytes [9];
    bus.popReady = 1'b0;

    // reset state
    #1 rstN = 1'b0;
    #1;
    chk("rst_popValid", bus.popValid, 0);
    chk("rst_count", count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_errCount", errCount, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // single frame: popValid rises on the 4th clk after rxDone rises
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h7A, 1'b0, 1'b0, 1'b1);
    chk("lat_pre", bus.popValid, 0);
    cyc(1'b1, 1'b0, 8'h7A, 1'b0, 1'b0, 1'b1);
    chk("lat_4clk", bus.popValid, 1);
    chk("one_data", bus.popData, 8'h7A);
    chk("one_count", count, 1);
    cyc(1'b1, 1'b0, 8'h7A, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h7A, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h7A, 1'b0, 1'b0, 1'b1);

    // second frame, then pop both in order
    frame(8'hB1, 1'b0, 5, 2, 1'b0);
    chk("two_count", count, 2);
    chk("two_head0", bus.popData, 8'h7A);
    cyc(1'b0, 1'b0, 8'hB1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'hB1, 1'b1, 1'b0, 1'b1);
    chk("two_head1", bus.popData, 8'hB1);
    cyc(1'b0, 1'b0, 8'hB1, 1'b0, 1'b0, 1'b1);
    chk("two_empty", bus.popValid, 0);
    chk("two_count0", count, 0);

    // overflow: 9 frames into 8 entries, no pops
    for (int i = 0; i < 9; i++) begin
      bytes[i] = 8'($urandom);
      frame(bytes[i], 1'b0, 5, 1, 1'b0);
    end
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", overrun, 1);
    cyc(1'b0, 1'b0, bytes[8], 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, bytes[8], 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", overrun, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_byte", bus.popData, bytes[i]);
      cyc(1'b0, 1'b0, bytes[8], 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, bytes[8], 1'b0, 1'b0, 1'b1);
    end
    chk("ovf_empty", bus.popValid, 0);

    // full FIFO, 9th capture coincides with a pop
    for (int i = 0; i < 9; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) frame(bytes[i], 1'b0, 5, 1, 1'b0);
    chk("fp_full", count, DEPTH);
    frame(bytes[8], 1'b0, 5, 1, 1'b1);
    chk("fp_overrun", overrun, 0);
    chk("fp_count", count, DEPTH);
    for (int i = 1; i < 9; i++) begin
      chk("fp_byte", bus.popData, bytes[i]);
      cyc(1'b0, 1'b0, bytes[8], 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, bytes[8], 1'b0, 1'b0, 1'b1);
    end
    chk("fp_empty", bus.popValid, 0);

    // error frame then good frame; then saturate the error counter
    frame(8'hE7, 1'b1, 5, 1, 1'b0);
    frame(8'h3C, 1'b0, 5, 1, 1'b0);
    chk("err_cnt1", errCount, 1);
    chk("err_count1", count, 1);
    drain();
    for (int i = 0; i < 300; i++) frame(8'($urandom), 1'b1, 4, 1, 1'b0);
    chk("err_sat", errCount, 255);

    // reset mid-frame with rxDone held high
    frame(8'h11, 1'b0, 5, 1, 1'b0);
    frame(8'h22, 1'b0, 5, 1, 1'b0);
    cyc(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mrst_popValid", bus.popValid, 0);
    chk("mrst_count", count, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_errCount", errCount, 0);
    cyc(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    chk("mrst_one", count, 1);
    chk("mrst_byte", bus.popData, 8'hC3);
    cyc(1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    drain();

    // randomized frames, pops and clears
    clr_pct = 4;
    for (int k = 0; k < 160; k++) begin
      pop_pct = (k < 80) ? 20 : 60;
      frame(8'($urandom), $urandom_range(4) == 0, $urandom_range(7, 4),
            $urandom_range(4, 1), 1'b0);
    end
    pop_pct = 0;
    clr_pct = 0;
    drain();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
